seq_checker: RTL and testbench
==============================

Name: seq_checker

Overview:
- Downstream monitor for the 3-bit sequence generator output. The generator runs the cyclic sequence 7,3,1,0,2,4,6.
- The checker samples the generator's State bus and acquires lock on the sequence. It then flags and counts deviations and counts completed periods.
- Sits beside the generator in the bench and in silicon, as a built-in self-check of the state register.

Parameters:
- LOCK_N, 4: consecutive correct valid samples, starting at a 7, needed to assert Locked (range 2..7).
- UNLOCK_N, 2: consecutive mismatches while locked that drop lock (range 1..7).
- CNT_W, 8: width of the saturating error and period counters.

Ports:
- Clk  in  1  single clock; all state updates on posedge.
- Rst  in  1  synchronous, active-high reset, sampled on posedge Clk.
- Valid  in  1  State_in is a sample this cycle; when low, all state holds.
- State_in  in  3  generator state to check.
- Locked  out  1  high while in LOCKED.
- Err  out  1  one-cycle pulse per mismatch detected in LOCKED.
- Err_cnt  out  CNT_W  saturating count of Err pulses.
- Period_cnt  out  CNT_W  saturating count of completed periods while locked.
- Expected  out  3  value predicted for the next valid sample.

Behaviour:
- Reset: while Rst is high at a posedge, the next state is SEARCH with Locked=0, Err=0, Err_cnt=0, Period_cnt=0, Expected=7, run=0, miss=0. Reset mid-operation has the same effect in any state and overrides Valid.
- Sequence function: next(7)=3, next(3)=1, next(1)=0, next(0)=2, next(2)=4, next(4)=6, next(6)=7. The value 5 is illegal; next(5)=7.
- All outputs are registered. A sample taken at edge k is reflected in outputs after edge k, i.e. 1-cycle latency.
- Valid=0: FSM, counters and Expected hold; Err=0.
- Err defaults to 0 on every edge unless set by the rules below.
- FSM states: SEARCH, TRACK, LOCKED. The 2-bit encoding is defined in the package.
- SEARCH: a valid sample of 7 moves to TRACK with run=1 and Expected=3. Any other value is ignored: no Err, no count.
- TRACK, valid sample == Expected:
  - run+1 == LOCK_N moves to LOCKED with miss=0.
  - Otherwise run increments.
  - In both cases Expected = next(sample).
- TRACK, valid sample != Expected:
  - Sample == 7 restarts TRACK with run=1 and Expected=3.
  - Otherwise move to SEARCH with Expected=7.
  - No Err in either case.
- LOCKED, match: miss=0 and Expected=next(sample). If the sample is 7, Period_cnt increments, saturating at all-ones.
- LOCKED, mismatch: Err=1 for one cycle, Err_cnt increments saturating, miss increments.
  - miss+1 == UNLOCK_N: move to SEARCH, Locked=0, Expected=7, run=0, miss=0.
  - Otherwise stay LOCKED (flywheel). If the sample is legal, Expected = next(sample), resynchronising. If the sample is 5, Expected = next(old Expected).
- Entry into LOCKED does not increment Period_cnt, even when the locking sample is 7.
- Counters never wrap. Err_cnt and Period_cnt persist across unlock/relock and clear only on Rst.
- Period boundary: a matched 7 in LOCKED counts one period.

Decomposition:
- Package seq_pkg holds the FSM state encoding localparams, the sequence start value (7), the illegal value (5), and function seq_next(3-bit) returning the successor. seq_pkg is shared with the generator so both sides use one table.
- One sub-module, seq_next_lut: a combinational 3-bit to 3-bit successor wrapper around seq_next, instantiated twice. One instance serves next(sample), the other next(Expected).
- The FSM, run/miss counters and saturating counters live in seq_checker.

Test Plan:
1. Rst for 2 cycles, then Valid=1 and feed 7,3,1,0,2,4,6,7,3 -> Locked rises after the 4th sample (0); Period_cnt=1 after the second 7; Err never high; Err_cnt=0.
2. When locked, replace one 0 with 5, then continue 2,4,6 -> single 1-cycle Err, Err_cnt=1; Locked stays 1; Expected=2 after the bad sample; the following 2,4,6 match.
3. When locked, feed 5,5 -> Err pulses on both samples; Err_cnt=2; Locked falls after the second; Expected=7; the next 7,3,1,0 relocks with Err_cnt still 2.
4. From reset, feed 0,2,4,6,7,3,1,0 -> no TRACK before the 7; Locked rises only on the final 0; Err=0 throughout.
5. Valid toggled 1,0,1,0 while the sequence is fed only on Valid=1 cycles -> same lock point counted in valid samples; all outputs hold on Valid=0 cycles; Err=0 on those cycles.
6. CNT_W=2, locked, inject 5 four times, each separated by three correct samples -> Err_cnt goes 1,2,3,3 (saturated); then Rst for one edge mid-LOCKED -> all outputs return to reset values on that edge.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared sequence definitions for the 3-bit generator and its checker.
// Both sides take the successor table from seq_next so they cannot drift apart.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'b00,
        ST_TRACK  = 2'b01,
        ST_LOCKED = 2'b10
    } seq_state_e;

    localparam logic [2:0] SEQ_START   = 3'd7;
    localparam logic [2:0] SEQ_ILLEGAL = 3'd5;

    // Cyclic order 7,3,1,0,2,4,6; the illegal value 5 re-enters at the start.
    function automatic logic [2:0] seq_next(input logic [2:0] cur);
        logic [2:0] succ;
        case (cur)
            3'd7:    succ = 3'd3;
            3'd3:    succ = 3'd1;
            3'd1:    succ = 3'd0;
            3'd0:    succ = 3'd2;
            3'd2:    succ = 3'd4;
            3'd4:    succ = 3'd6;
            3'd6:    succ = 3'd7;
            default: succ = SEQ_START;
        endcase
        return succ;
    endfunction

endpackage

// File: rtl/seq_checker_if.sv
// Sample/status bundle between the generator side and the sequence checker.
interface seq_checker_if #(
    parameter int CNT_W = 8
);
    logic             Valid;
    logic [2:0]       State_in;
    logic             Locked;
    logic             Err;
    logic [CNT_W-1:0] Err_cnt;
    logic [CNT_W-1:0] Period_cnt;
    logic [2:0]       Expected;

    modport master (
        output Valid, State_in,
        input  Locked, Err, Err_cnt, Period_cnt, Expected
    );

    modport slave (
        input  Valid, State_in,
        output Locked, Err, Err_cnt, Period_cnt, Expected
    );
endinterface

// File: rtl/seq_next_lut.sv
// Combinational successor lookup for one 3-bit sequence value.
module seq_next_lut
    import seq_pkg::*;
(
    input  logic [2:0] cur,
    output logic [2:0] succ
);
    assign succ = seq_next(cur);
endmodule

// File: rtl/seq_checker.sv
// Locks onto the 7,3,1,0,2,4,6 sequence, flags and counts deviations while
// locked, and counts completed periods.
module seq_checker
    import seq_pkg::*;
#(
    parameter int LOCK_N   = 4,
    parameter int UNLOCK_N = 2,
    parameter int CNT_W    = 8
) (
    input logic         Clk,
    input logic         Rst,
    seq_checker_if.slave bus
);
    localparam logic [3:0]       LOCK_T   = 4'(LOCK_N);
    localparam logic [3:0]       UNLOCK_T = 4'(UNLOCK_N);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    seq_state_e       state_q, state_d;
    logic [2:0]       run_q, run_d;
    logic [2:0]       miss_q, miss_d;
    logic [2:0]       exp_q, exp_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [2:0]       nxt_sample, nxt_expected;
    logic             match;

    seq_next_lut u_next_sample (.cur(bus.State_in), .succ(nxt_sample));
    seq_next_lut u_next_expected (.cur(exp_q), .succ(nxt_expected));

    assign match = (bus.State_in == exp_q);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_SEARCH;
            run_q   <= '0;
            miss_q  <= '0;
            exp_q   <= SEQ_START;
            err_q   <= 1'b0;
            ecnt_q  <= '0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            miss_q  <= miss_d;
            exp_q   <= exp_d;
            err_q   <= err_d;
            ecnt_q  <= ecnt_d;
            pcnt_q  <= pcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        miss_d  = miss_q;
        exp_d   = exp_q;
        err_d   = 1'b0;
        ecnt_d  = ecnt_q;
        pcnt_d  = pcnt_q;

        if (bus.Valid) begin
            case (state_q)
                ST_SEARCH: begin
                    if (bus.State_in == SEQ_START) begin
                        state_d = ST_TRACK;
                        run_d   = 3'd1;
                        exp_d   = nxt_sample;
                    end
                end
                ST_TRACK: begin
                    if (match) begin
                        exp_d = nxt_sample;
                        if (({1'b0, run_q} + 4'd1) == LOCK_T) begin
                            state_d = ST_LOCKED;
                            run_d   = '0;
                            miss_d  = '0;
                        end else begin
                            run_d = run_q + 3'd1;
                        end
                    end else if (bus.State_in == SEQ_START) begin
                        run_d = 3'd1;
                        exp_d = nxt_sample;
                    end else begin
                        state_d = ST_SEARCH;
                        run_d   = '0;
                        exp_d   = SEQ_START;
                    end
                end
                ST_LOCKED: begin
                    if (match) begin
                        miss_d = '0;
                        exp_d  = nxt_sample;
                        if (bus.State_in == SEQ_START && pcnt_q != '1)
                            pcnt_d = pcnt_q + CNT_ONE;
                    end else begin
                        err_d = 1'b1;
                        if (ecnt_q != '1)
                            ecnt_d = ecnt_q + CNT_ONE;
                        if (({1'b0, miss_q} + 4'd1) == UNLOCK_T) begin
                            state_d = ST_SEARCH;
                            exp_d   = SEQ_START;
                            run_d   = '0;
                            miss_d  = '0;
                        end else begin
                            // Flywheel: a legal sample resynchronises, an illegal one keeps the old phase.
                            miss_d = miss_q + 3'd1;
                            exp_d  = (bus.State_in == SEQ_ILLEGAL) ? nxt_expected : nxt_sample;
                        end
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                    run_d   = '0;
                    miss_d  = '0;
                    exp_d   = SEQ_START;
                end
            endcase
        end
    end

    assign bus.Locked     = (state_q == ST_LOCKED);
    assign bus.Err        = err_q;
    assign bus.Err_cnt    = ecnt_q;
    assign bus.Period_cnt = pcnt_q;
    assign bus.Expected   = exp_q;

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench: a default checker and a CNT_W=2 checker see identical stimulus.
module tb_seq_checker;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    seq_checker_if #(.CNT_W(8)) bus_a ();
    seq_checker_if #(.CNT_W(2)) bus_b ();

    seq_checker #(.LOCK_N(4), .UNLOCK_N(2), .CNT_W(8)) u_dut_a (
        .Clk(Clk), .Rst(Rst), .bus(bus_a.slave)
    );
    seq_checker #(.LOCK_N(4), .UNLOCK_N(2), .CNT_W(2)) u_dut_b (
        .Clk(Clk), .Rst(Rst), .bus(bus_b.slave)
    );

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Apply one sample, then compare both checkers one edge later.
    task automatic feed(input string tag, input logic v, input logic [2:0] s,
                        input logic el, input logic ee, input int ec,
                        input int pc, input logic [2:0] ex);
        @(negedge Clk);
        bus_a.Valid = v; bus_a.State_in = s;
        bus_b.Valid = v; bus_b.State_in = s;
        @(posedge Clk);
        #1;
        check({tag, " locked"},   int'(bus_a.Locked),     int'(el));
        check({tag, " err"},      int'(bus_a.Err),        int'(ee));
        check({tag, " err_cnt"},  int'(bus_a.Err_cnt),    ec);
        check({tag, " per_cnt"},  int'(bus_a.Period_cnt), pc);
        check({tag, " expected"}, int'(bus_a.Expected),   int'(ex));
        check({tag, " w2 locked"},   int'(bus_b.Locked),     int'(el));
        check({tag, " w2 err"},      int'(bus_b.Err),        int'(ee));
        check({tag, " w2 err_cnt"},  int'(bus_b.Err_cnt),    (ec > 3) ? 3 : ec);
        check({tag, " w2 per_cnt"},  int'(bus_b.Period_cnt), (pc > 3) ? 3 : pc);
        check({tag, " w2 expected"}, int'(bus_b.Expected),   int'(ex));
    endtask

    initial begin
        bus_a.Valid = 1'b0; bus_a.State_in = 3'd0;
        bus_b.Valid = 1'b0; bus_b.State_in = 3'd0;

        // 1: reset, lock on the 4th sample, one period at the second 7
        Rst = 1'b1;
        feed("t1 rst0", 1'b1, 3'd7, 0, 0, 0, 0, 3'd7);
        feed("t1 rst1", 1'b0, 3'd0, 0, 0, 0, 0, 3'd7);
        Rst = 1'b0;
        feed("t1 s7",  1'b1, 3'd7, 0, 0, 0, 0, 3'd3);
        feed("t1 s3",  1'b1, 3'd3, 0, 0, 0, 0, 3'd1);
        feed("t1 s1",  1'b1, 3'd1, 0, 0, 0, 0, 3'd0);
        feed("t1 s0",  1'b1, 3'd0, 1, 0, 0, 0, 3'd2);
        feed("t1 s2",  1'b1, 3'd2, 1, 0, 0, 0, 3'd4);
        feed("t1 s4",  1'b1, 3'd4, 1, 0, 0, 0, 3'd6);
        feed("t1 s6",  1'b1, 3'd6, 1, 0, 0, 0, 3'd7);
        feed("t1 s7b", 1'b1, 3'd7, 1, 0, 0, 1, 3'd3);
        feed("t1 s3b", 1'b1, 3'd3, 1, 0, 0, 1, 3'd1);

        // 2: single illegal sample in place of 0, flywheel keeps phase
        feed("t2 s1",  1'b1, 3'd1, 1, 0, 0, 1, 3'd0);
        feed("t2 s5",  1'b1, 3'd5, 1, 1, 1, 1, 3'd2);
        feed("t2 s2",  1'b1, 3'd2, 1, 0, 1, 1, 3'd4);
        feed("t2 s4",  1'b1, 3'd4, 1, 0, 1, 1, 3'd6);
        feed("t2 s6",  1'b1, 3'd6, 1, 0, 1, 1, 3'd7);

        // 3: two misses drop lock, counters persist through relock
        feed("t3 s5a", 1'b1, 3'd5, 1, 1, 2, 1, 3'd3);
        feed("t3 s5b", 1'b1, 3'd5, 0, 1, 3, 1, 3'd7);
        feed("t3 s7",  1'b1, 3'd7, 0, 0, 3, 1, 3'd3);
        feed("t3 s3",  1'b1, 3'd3, 0, 0, 3, 1, 3'd1);
        feed("t3 s1",  1'b1, 3'd1, 0, 0, 3, 1, 3'd0);
        feed("t3 s0",  1'b1, 3'd0, 1, 0, 3, 1, 3'd2);

        // 4: TRACK restart on 7, TRACK abort, SEARCH ignores non-7 values
        Rst = 1'b1;
        feed("t4 rst", 1'b1, 3'd2, 0, 0, 0, 0, 3'd7);
        Rst = 1'b0;
        feed("t4 r7",  1'b1, 3'd7, 0, 0, 0, 0, 3'd3);
        feed("t4 r3",  1'b1, 3'd3, 0, 0, 0, 0, 3'd1);
        feed("t4 r7b", 1'b1, 3'd7, 0, 0, 0, 0, 3'd3);
        feed("t4 r3b", 1'b1, 3'd3, 0, 0, 0, 0, 3'd1);
        feed("t4 r1",  1'b1, 3'd1, 0, 0, 0, 0, 3'd0);
        feed("t4 r4",  1'b1, 3'd4, 0, 0, 0, 0, 3'd7);
        feed("t4 s0",  1'b1, 3'd0, 0, 0, 0, 0, 3'd7);
        feed("t4 s2",  1'b1, 3'd2, 0, 0, 0, 0, 3'd7);
        feed("t4 s4",  1'b1, 3'd4, 0, 0, 0, 0, 3'd7);
        feed("t4 s6",  1'b1, 3'd6, 0, 0, 0, 0, 3'd7);
        feed("t4 s7",  1'b1, 3'd7, 0, 0, 0, 0, 3'd3);
        feed("t4 s3",  1'b1, 3'd3, 0, 0, 0, 0, 3'd1);
        feed("t4 s1",  1'b1, 3'd1, 0, 0, 0, 0, 3'd0);
        feed("t4 s0b", 1'b1, 3'd0, 1, 0, 0, 0, 3'd2);

        // 5: Valid gaps carry garbage and must leave everything held
        Rst = 1'b1;
        feed("t5 rst", 1'b0, 3'd0, 0, 0, 0, 0, 3'd7);
        Rst = 1'b0;
        feed("t5 v7",  1'b1, 3'd7, 0, 0, 0, 0, 3'd3);
        feed("t5 g1",  1'b0, 3'd5, 0, 0, 0, 0, 3'd3);
        feed("t5 v3",  1'b1, 3'd3, 0, 0, 0, 0, 3'd1);
        feed("t5 g2",  1'b0, 3'd7, 0, 0, 0, 0, 3'd1);
        feed("t5 v1",  1'b1, 3'd1, 0, 0, 0, 0, 3'd0);
        feed("t5 g3",  1'b0, 3'd0, 0, 0, 0, 0, 3'd0);
        feed("t5 v0",  1'b1, 3'd0, 1, 0, 0, 0, 3'd2);
        feed("t5 g4",  1'b0, 3'd5, 1, 0, 0, 0, 3'd2);
        feed("t5 g5",  1'b0, 3'd5, 1, 0, 0, 0, 3'd2);
        feed("t5 v2",  1'b1, 3'd2, 1, 0, 0, 0, 3'd4);

        // 6: periodic illegal samples saturate the narrow counter, then reset mid-lock
        Rst = 1'b1;
        feed("t6 rst", 1'b0, 3'd0, 0, 0, 0, 0, 3'd7);
        Rst = 1'b0;
        feed("t6 l7",  1'b1, 3'd7, 0, 0, 0, 0, 3'd3);
        feed("t6 l3",  1'b1, 3'd3, 0, 0, 0, 0, 3'd1);
        feed("t6 l1",  1'b1, 3'd1, 0, 0, 0, 0, 3'd0);
        feed("t6 l0",  1'b1, 3'd0, 1, 0, 0, 0, 3'd2);
        feed("t6 e1",  1'b1, 3'd5, 1, 1, 1, 0, 3'd4);
        feed("t6 a4",  1'b1, 3'd4, 1, 0, 1, 0, 3'd6);
        feed("t6 a6",  1'b1, 3'd6, 1, 0, 1, 0, 3'd7);
        feed("t6 a7",  1'b1, 3'd7, 1, 0, 1, 1, 3'd3);
        feed("t6 e2",  1'b1, 3'd5, 1, 1, 2, 1, 3'd1);
        feed("t6 b1",  1'b1, 3'd1, 1, 0, 2, 1, 3'd0);
        feed("t6 b0",  1'b1, 3'd0, 1, 0, 2, 1, 3'd2);
        feed("t6 b2",  1'b1, 3'd2, 1, 0, 2, 1, 3'd4);
        feed("t6 e3",  1'b1, 3'd5, 1, 1, 3, 1, 3'd6);
        feed("t6 c6",  1'b1, 3'd6, 1, 0, 3, 1, 3'd7);
        feed("t6 c7",  1'b1, 3'd7, 1, 0, 3, 2, 3'd3);
        feed("t6 c3",  1'b1, 3'd3, 1, 0, 3, 2, 3'd1);
        feed("t6 e4",  1'b1, 3'd5, 1, 1, 4, 2, 3'd0);
        feed("t6 d0",  1'b1, 3'd0, 1, 0, 4, 2, 3'd2);
        Rst = 1'b1;
        feed("t6 rstm", 1'b1, 3'd2, 0, 0, 0, 0, 3'd7);
        Rst = 1'b0;
        feed("t6 post", 1'b1, 3'd3, 0, 0, 0, 0, 3'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
